// File: rtl/branch_resolve_unit_if.sv
// Fetch-to-EX branch bus: prediction push, EX resolve, and flush/redirect/training/perf outputs.
// master = pipeline side driving pushes and resolves; slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             i_push_valid;
  logic [PC_W-1:0]  i_push_pc;
  logic             i_push_pred_taken;
  logic [PC_W-1:0]  i_push_pred_target;
  logic             o_push_ready;

  logic             i_res_valid;
  logic [PC_W-1:0]  i_res_pc;
  logic             i_res_taken;
  logic [PC_W-1:0]  i_res_target;

  logic             o_flush;
  logic [PC_W-1:0]  o_redirect_pc;
  logic             o_update_valid;
  logic             o_update_taken;
  logic             o_error;
  logic [CNT_W-1:0] o_branch_cnt;
  logic [CNT_W-1:0] o_mispredict_cnt;

  modport master (
    output i_push_valid, i_push_pc, i_push_pred_taken, i_push_pred_target,
    output i_res_valid, i_res_pc, i_res_taken, i_res_target,
    input  o_push_ready, o_flush, o_redirect_pc, o_update_valid, o_update_taken,
    input  o_error, o_branch_cnt, o_mispredict_cnt
  );

  modport slave (
    input  i_push_valid, i_push_pc, i_push_pred_taken, i_push_pred_target,
    input  i_res_valid, i_res_pc, i_res_taken, i_res_target,
    output o_push_ready, o_flush, o_redirect_pc, o_update_valid, o_update_taken,
    output o_error, o_branch_cnt, o_mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Queues fetch predictions and checks them at EX; flush/redirect/update registered 1 cycle after resolve.
// Push stalls when full (unless popping) and during FLUSH; perf counters exist only with `BR_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  branch_resolve_unit_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
  } pred_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  pred_t            mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0] occ_q;

  pred_t            head;
  logic             q_empty, q_full;
  logic             res_acc, push_rdy;
  logic             pop, push, mispredict, err_cause;
  logic [PC_W-1:0]  redirect_d;

  logic             flush_q;
  logic [PC_W-1:0]  redirect_q;
  logic             upd_vld_q, upd_taken_q, error_q;

  assign head    = mem_q[rd_ptr_q];
  assign q_empty = (occ_q == '0);
  assign q_full  = (occ_q == OCC_FULL);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (mispredict) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Resolves and pushes in FLUSH belong to the wrong path, so both are shut off there.
  always_comb begin
    res_acc  = 1'b0;
    push_rdy = 1'b0;
    case (state_q)
      ST_RUN: begin
        res_acc  = bus.i_res_valid;
        push_rdy = ~q_full | (bus.i_res_valid & ~q_empty);
      end
      default: ;
    endcase
  end

  // An empty-queue resolve has no prediction to trust, so it always redirects.
  assign pop        = res_acc & ~q_empty;
  assign mispredict = res_acc & (q_empty
                    | (head.pred_taken != bus.i_res_taken)
                    | (bus.i_res_taken & (head.pred_target != bus.i_res_target)));
  assign err_cause  = res_acc & (q_empty | (head.pc != bus.i_res_pc));
  assign push       = bus.i_push_valid & push_rdy & ~mispredict;
  assign redirect_d = bus.i_res_taken ? bus.i_res_target : bus.i_res_pc + PC_W'(4);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || mispredict) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc:          bus.i_push_pc,
                           pred_taken:  bus.i_push_pred_taken,
                           pred_target: bus.i_push_pred_target};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      upd_vld_q   <= 1'b0;
      upd_taken_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      flush_q     <= mispredict;
      if (mispredict) redirect_q <= redirect_d;
      upd_vld_q   <= res_acc;
      upd_taken_q <= res_acc & bus.i_res_taken;
      if (err_cause) error_q <= 1'b1;
    end
  end

`ifdef BR_PERF_CNT_EN
  logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (res_acc)    branch_cnt_q     <= branch_cnt_q + CNT_W'(1);
      if (mispredict) mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
    end
  end

  assign bus.o_branch_cnt     = branch_cnt_q;
  assign bus.o_mispredict_cnt = mispredict_cnt_q;
`else
  assign bus.o_branch_cnt     = '0;
  assign bus.o_mispredict_cnt = '0;
`endif

  assign bus.o_push_ready   = push_rdy;
  assign bus.o_flush        = flush_q;
  assign bus.o_redirect_pc  = redirect_q;
  assign bus.o_update_valid = upd_vld_q;
  assign bus.o_update_taken = upd_taken_q;
  assign bus.o_error        = error_q;
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage companion to the 2-bit branch predictor. It queues each prediction issued at fetch and checks it against the actual outcome when the branch resolves in EX. On a wrong prediction it generates the pipeline flush and redirect PC. Every resolved branch produces a training update for the predictor's `i_actual_branch_taken` input.

## Interface
Parameters:
- `DEPTH`, 4: in-flight prediction queue entries; power of two, ≥ 2.
- `PC_W`, 32: PC and target width.
- `CNT_W`, 32: performance counter width.

Ports:
- `i_clk` in 1: clock; single clock domain.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_push_valid` in 1: fetch issued a prediction for a branch.
- `i_push_pc` in PC_W: PC of the predicted branch.
- `i_push_pred_taken` in 1: predicted direction.
- `i_push_pred_target` in PC_W: predicted target; meaningful only when taken is predicted.
- `o_push_ready` out 1: queue can accept a push.
- `i_res_valid` in 1: EX resolved a branch this cycle.
- `i_res_pc` in PC_W: PC of the resolved branch.
- `i_res_taken` in 1: actual direction.
- `i_res_target` in PC_W: actual computed target.
- `o_flush` out 1: one-cycle flush pulse to IF/ID/EX.
- `o_redirect_pc` out PC_W: correct next PC; valid while `o_flush` is high.
- `o_update_valid` out 1: training strobe to the predictor.
- `o_update_taken` out 1: actual outcome, feeds `i_actual_branch_taken`.
- `o_error` out 1: sticky protocol error.
- `o_branch_cnt` out CNT_W: resolved-branch count (macro-gated).
- `o_mispredict_cnt` out CNT_W: mispredict count (macro-gated).

## Operation
- **Queue.** FIFO of {pc, pred_taken, pred_target} with read/write pointers and an occupancy counter sized 0..DEPTH.
  - Push is accepted when `i_push_valid & o_push_ready`.
  - A pop happens on every accepted resolve.
- **FSM states: RUN, FLUSH.**
  - In RUN, `o_push_ready` = ~full | pop-this-cycle; a push to a full queue succeeds if a pop occurs in the same cycle.
  - A resolve is accepted in RUN only.
  - In FLUSH, `o_push_ready`=0 and `i_res_valid` is ignored, since those are wrong-path instructions.
  - FLUSH always returns to RUN after exactly one cycle.
- **Compare on an accepted resolve.** Against the queue head:
  - mispredict = (head.pred_taken != i_res_taken) | (i_res_taken & head.pred_target != i_res_target).
  - Redirect = i_res_taken ? i_res_target : i_res_pc + 4. The addition is modulo 2^PC_W.
- **Mispredict.**
  - Next cycle: state goes to FLUSH, `o_flush`=1, and `o_redirect_pc` is registered.
  - The whole queue is cleared, because all remaining entries are younger.
  - A push arriving in the mispredicting cycle is dropped.
- **Correct prediction.** Pop only; no flush.
- **Update.** Every accepted resolve, correct or not, produces `o_update_valid`=1 and `o_update_taken`=i_res_taken in the next cycle.
- **Errors.** `o_error` is set and held until reset when:
  - a resolve is accepted while the queue is empty; or
  - `i_res_pc` != head.pc.

  On an error-causing resolve:
  - If the queue is empty: no pop, and the branch is treated as a mispredict with pred_taken=0.
  - On a PC mismatch: normal pop and compare.

## Timing
- All outputs are registered except `o_push_ready`.
  - `o_push_ready` is combinational from state, occupancy and the current resolve.
- Latency from resolve to `o_flush`, `o_redirect_pc` and `o_update_*` is 1 cycle.
- `o_flush` stays high for exactly one cycle. Back-to-back flushes are impossible, because FLUSH blocks resolves.
- Queue pointers wrap modulo DEPTH.
- **Reset** (`i_rst_n`=0 at a clock edge), including mid-FLUSH:
  - state=RUN, queue empty, pointers 0, `o_push_ready`=1.
  - `o_flush`=0, `o_redirect_pc`=0, `o_update_valid`=0, `o_update_taken`=0, `o_error`=0.
  - Counters = 0.

## Configuration
- Macro: `BR_PERF_CNT_EN`.
- **Defined:**
  - `o_branch_cnt` increments on every accepted resolve.
  - `o_mispredict_cnt` increments on every mispredict.
  - Both wrap at 2^CNT_W.
- **Undefined:** both outputs are tied to 0 and no counter flops are synthesized. All other behaviour is identical.

## Test plan
- **Correct prediction.** Push pc=0x100, pred_taken=1, target=0x200. Resolve pc=0x100, taken=1, target=0x200. Expect: `o_flush`=0; `o_update_valid`=1 and `o_update_taken`=1 next cycle; queue empty.
- **Direction mispredict.** Push pc=0x100, pred_taken=1. Resolve taken=0. Expect: `o_flush`=1 for one cycle; `o_redirect_pc`=0x104; queue cleared; `o_mispredict_cnt`=1 with `BR_PERF_CNT_EN`.
- **Target mispredict with same-cycle push.** Push pc=0x10, pred_taken=1, target=0x40, then one further push. Resolve pc=0x10, taken=1, target=0x80, with a push in the same cycle. Expect: `o_redirect_pc`=0x80; that push dropped; occupancy 0; `o_push_ready`=0 during FLUSH, then 1.
- **Full queue and wrap.** Fill DEPTH=4 entries; check `o_push_ready`=0. Do a simultaneous push and correct resolve; expect the push accepted with occupancy still 4. Repeat 10 times to exercise pointer wrap; entries must pop in FIFO order.
- **Empty resolve.** Resolve with the queue empty, taken=1, target=0x300. Expect: `o_error`=1 sticky; `o_flush`=1; `o_redirect_pc`=0x300.
- **Reset mid-operation.** Hold `i_rst_n`=0 during FLUSH with 3 entries queued. Expect all outputs at their reset values on the next edge, and the queue empty.
